// File: rtl/rotate_sequencer.sv
// rotate_sequencer: multi-cycle rotate unit for a {link, accumulator} register pair.
//
// A Start in IDLE captures the operand and the operation, then the unit performs
// one 1-bit step per SHIFT cycle until the step count is exhausted. It then
// pulses Done for one cycle and returns to IDLE.
//
// Ports
//   clk     : clock, all state updates on the rising edge
//   reset   : synchronous active-high reset
//   Start   : request strobe, only honoured in IDLE
//   Op      : 001 RAL, 010 RTL, 011 RAR, 100 RTR, 101 BSW, others NOP
//   AcIn    : accumulator operand, captured with Start
//   LinkIn  : link operand, captured with Start
//   AcOut   : registered accumulator result
//   LinkOut : registered link result
//   Busy    : high while stepping
//   Done    : one-cycle completion pulse

module rotate_sequencer #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] AcIn,
    input  logic             LinkIn,
    output logic [WIDTH-1:0] AcOut,
    output logic             LinkOut,
    output logic             Busy,
    output logic             Done
);

    // Counter must hold both WIDTH/2 (BSW) and 2 (RTL/RTR), even for WIDTH=2.
    localparam int unsigned MaxSteps = ((WIDTH / 2) > 2) ? (WIDTH / 2) : 2;
    localparam int unsigned CW       = $clog2(MaxSteps + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        KindLeft,
        KindRight,
        KindSwap
    } kind_e;

    state_e          r_state;
    kind_e           r_kind;
    logic [CW-1:0]   r_count;
    logic [WIDTH-1:0] r_ac;
    logic            r_link;
    logic            r_busy;
    logic            r_done;

    kind_e           w_kind;
    logic [CW-1:0]   w_count;
    logic [WIDTH-1:0] w_ac_step;
    logic            w_link_step;

    // Decode the requested operation into a step kind and a step count.
    always_comb begin
        w_kind  = KindLeft;
        w_count = '0;
        case (Op)
            3'b001: begin
                w_kind  = KindLeft;
                w_count = CW'(1);
            end
            3'b010: begin
                w_kind  = KindLeft;
                w_count = CW'(2);
            end
            3'b011: begin
                w_kind  = KindRight;
                w_count = CW'(1);
            end
            3'b100: begin
                w_kind  = KindRight;
                w_count = CW'(2);
            end
            3'b101: begin
                w_kind  = KindSwap;
                w_count = CW'(WIDTH / 2);
            end
            default: begin
                w_kind  = KindLeft;
                w_count = '0;
            end
        endcase
    end

    // One 1-bit step on the registered {link, ac} pair.
    always_comb begin
        w_ac_step   = r_ac;
        w_link_step = r_link;
        case (r_kind)
            KindLeft: begin
                w_link_step = r_ac[WIDTH-1];
                w_ac_step   = {r_ac[WIDTH-2:0], r_link};
            end
            KindRight: begin
                w_link_step = r_ac[0];
                w_ac_step   = {r_link, r_ac[WIDTH-1:1]};
            end
            KindSwap: begin
                // Plain rotate of the accumulator; WIDTH/2 of these swap the halves.
                w_ac_step   = {r_ac[WIDTH-2:0], r_ac[WIDTH-1]};
            end
            default: begin
                w_ac_step   = r_ac;
                w_link_step = r_link;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_kind  <= KindLeft;
            r_count <= '0;
            r_ac    <= '0;
            r_link  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (Start) begin
                        r_ac    <= AcIn;
                        r_link  <= LinkIn;
                        r_kind  <= w_kind;
                        r_count <= w_count;
                        if (w_count != '0) begin
                            r_state <= StShift;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end
                    end
                end
                StShift: begin
                    r_ac    <= w_ac_step;
                    r_link  <= w_link_step;
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign AcOut   = r_ac;
    assign LinkOut = r_link;
    assign Busy    = r_busy;
    assign Done    = r_done;

endmodule

// File: tb/tb_rotate_sequencer.sv
// tb_rotate_sequencer: directed checks of rotate_sequencer at WIDTH=12 (octal vectors).

module tb_rotate_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  Op;
    logic [11:0] AcIn;
    logic        LinkIn;
    logic [11:0] AcOut;
    logic        LinkOut;
    logic        Busy;
    logic        Done;

    int n_checks = 0;
    int n_fail   = 0;

    rotate_sequencer #(
        .WIDTH(12)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .Op     (Op),
        .AcIn   (AcIn),
        .LinkIn (LinkIn),
        .AcOut  (AcOut),
        .LinkOut(LinkOut),
        .Busy   (Busy),
        .Done   (Done)
    );

    always #5 clk = ~clk;

    // Issues one Start and observes 20 cycles starting at the negedge after the
    // accepting edge (index 0). Optionally pulses a second Start at inject_at
    // and asserts reset at reset_at; snap holds {AcOut,LinkOut,Busy,Done} at
    // index reset_at+1.
    task automatic run_op(input logic [2:0] op, input logic [11:0] ac, input logic link,
                          input int inject_at, input int reset_at,
                          output int busy_n, output int done_at, output int done_n,
                          output int overlap_n, output logic [11:0] ac_res,
                          output logic link_res, output logic [14:0] snap,
                          output logic [11:0] ac_end, output logic link_end);
        @(negedge clk);
        Op     = op;
        AcIn   = ac;
        LinkIn = link;
        Start  = 1'b1;
        @(negedge clk);
        // Operands are don't-care after the accept edge.
        Op        = 3'b110;
        AcIn      = ~ac;
        LinkIn    = ~link;
        busy_n    = 0;
        done_at   = -1;
        done_n    = 0;
        overlap_n = 0;
        ac_res    = 'x;
        link_res  = 1'bx;
        snap      = 'x;
        for (int i = 0; i < 20; i++) begin
            if (Busy) busy_n++;
            if (Done) begin
                if (done_n == 0) done_at = i;
                done_n++;
                ac_res   = AcOut;
                link_res = LinkOut;
            end
            if (Busy && Done) overlap_n++;
            if (i == reset_at + 1) begin
                snap  = {AcOut, LinkOut, Busy, Done};
                reset = 1'b0;
            end
            Start = 1'b0;
            if (i == inject_at) begin
                Start  = 1'b1;
                Op     = 3'b001;
                AcIn   = 12'o0001;
                LinkIn = 1'b1;
            end
            if (i == reset_at) reset = 1'b1;
            @(negedge clk);
        end
        ac_end   = AcOut;
        link_end = LinkOut;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        Start = 1'b0;
        Op    = 3'b000;
        AcIn  = '0;
        LinkIn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({AcOut, LinkOut, Busy, Done} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", {AcOut, LinkOut, Busy, Done});
        end
        // Start coincident with reset must be dropped.
        Start  = 1'b1;
        Op     = 3'b001;
        AcIn   = 12'o4001;
        LinkIn = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        Start = 1'b0;
        n_checks++;
        if ({AcOut, LinkOut, Busy, Done} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_start_drop: got %h want 0", {AcOut, LinkOut, Busy, Done});
        end
        @(negedge clk);
        n_checks++;
        if ({AcOut, LinkOut, Busy, Done} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_start_idle: got %h want 0", {AcOut, LinkOut, Busy, Done});
        end
    endtask

    task automatic test_rotate(input string name, input logic [2:0] op, input logic [11:0] ac,
                               input logic link, input int n,
                               input logic [11:0] exp_ac, input logic exp_link);
        int busy_n, done_at, done_n, overlap_n;
        logic [11:0] ac_res, ac_end;
        logic link_res, link_end;
        logic [14:0] snap;
        run_op(op, ac, link, -1, -10, busy_n, done_at, done_n, overlap_n,
               ac_res, link_res, snap, ac_end, link_end);
        n_checks++;
        if (busy_n !== n) begin
            n_fail++;
            $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy_n, n);
        end
        n_checks++;
        if (done_at !== n || done_n !== 1) begin
            n_fail++;
            $display("FAIL %s_done: at %0d count %0d want at %0d count 1",
                     name, done_at, done_n, n);
        end
        n_checks++;
        if (overlap_n !== 0) begin
            n_fail++;
            $display("FAIL %s_busy_done_overlap: got %0d want 0", name, overlap_n);
        end
        n_checks++;
        if (ac_res !== exp_ac || link_res !== exp_link) begin
            n_fail++;
            $display("FAIL %s_result: got %o/%b want %o/%b",
                     name, ac_res, link_res, exp_ac, exp_link);
        end
        n_checks++;
        if (ac_end !== exp_ac || link_end !== exp_link || Busy !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_hold_idle: got %o/%b busy %b done %b want %o/%b idle",
                     name, ac_end, link_end, Busy, Done, exp_ac, exp_link);
        end
    endtask

    task automatic test_ignored_start(input int inject_at);
        int busy_n, done_at, done_n, overlap_n;
        logic [11:0] ac_res, ac_end;
        logic link_res, link_end;
        logic [14:0] snap;
        run_op(3'b101, 12'o1234, 1'b1, inject_at, -10, busy_n, done_at, done_n, overlap_n,
               ac_res, link_res, snap, ac_end, link_end);
        n_checks++;
        if (done_n !== 1 || done_at !== 6 || busy_n !== 6) begin
            n_fail++;
            $display("FAIL ignore_start_%0d_timing: done %0d at %0d busy %0d want 1 at 6 busy 6",
                     inject_at, done_n, done_at, busy_n);
        end
        n_checks++;
        if (ac_res !== 12'o3412 || link_res !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_start_%0d_result: got %o/%b want 3412/1",
                     inject_at, ac_res, link_res);
        end
        n_checks++;
        if (ac_end !== 12'o3412 || Busy !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start_%0d_idle: got %o busy %b done %b want 3412 idle",
                     inject_at, ac_end, Busy, Done);
        end
    endtask

    task automatic test_reset_midway;
        int busy_n, done_at, done_n, overlap_n;
        logic [11:0] ac_res, ac_end;
        logic link_res, link_end;
        logic [14:0] snap;
        run_op(3'b101, 12'o1234, 1'b1, -1, 2, busy_n, done_at, done_n, overlap_n,
               ac_res, link_res, snap, ac_end, link_end);
        n_checks++;
        if (snap !== 15'd0) begin
            n_fail++;
            $display("FAIL midway_reset_outputs: got %h want 0", snap);
        end
        n_checks++;
        if (done_n !== 0 || busy_n !== 3) begin
            n_fail++;
            $display("FAIL midway_reset_no_done: done %0d busy %0d want 0 and 3", done_n, busy_n);
        end
        test_rotate("ral_after_reset", 3'b001, 12'o4001, 1'b0, 1, 12'o0002, 1'b1);
    endtask

    task automatic test_back_to_back;
        test_rotate("b2b_rar", 3'b011, 12'o0001, 1'b0, 1, 12'o0000, 1'b1);
        test_rotate("b2b_ral", 3'b001, 12'o0000, 1'b1, 1, 12'o0001, 1'b0);
    endtask

    initial begin
        test_reset();
        test_rotate("ral", 3'b001, 12'o4001, 1'b0, 1, 12'o0002, 1'b1);
        test_rotate("rtr", 3'b100, 12'o0003, 1'b0, 2, 12'o4000, 1'b1);
        test_rotate("rtl", 3'b010, 12'o7777, 1'b0, 2, 12'o7775, 1'b1);
        test_rotate("bsw", 3'b101, 12'o1234, 1'b1, 6, 12'o3412, 1'b1);
        test_rotate("nop000", 3'b000, 12'o5555, 1'b1, 0, 12'o5555, 1'b1);
        test_rotate("nop111", 3'b111, 12'o5555, 1'b1, 0, 12'o5555, 1'b1);
        test_ignored_start(2);
        test_ignored_start(6);
        test_reset_midway();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
